// File: rtl/cc_sequencer.sv
// Machine-cycle sequencer and condition-code unit for the TB4004 core.
// Walks the slot counter, latches OPR/OPA, tracks two-word instructions, drives write strobes and owns the flags.
module cc_sequencer #(
    parameter int DATA_W    = 4,
    parameter int NCYC      = 8,
    parameter int TEST_SYNC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step,
    input  logic [3:0]              opr,
    input  logic [3:0]              opa,
    input  logic [DATA_W-1:0]       aluResult,
    input  logic                    aluCarry,
    input  logic                    testIn,
    output logic [$clog2(NCYC)-1:0] cycle,
    output logic                    secondWord,
    output logic                    aluEnable,
    output logic [4:0]              aluOp,
    output logic                    accWe,
    output logic                    regWe,
    output logic                    tempWe,
    output logic                    carryFlag,
    output logic                    zeroFlag,
    output logic                    testFlag,
    output logic                    branchTaken,
    output logic                    useImm
);

    localparam int CW = $clog2(NCYC);
    localparam logic [CW-1:0] M1 = CW'(3);
    localparam logic [CW-1:0] M2 = CW'(4);
    localparam logic [CW-1:0] X1 = CW'(5);
    localparam logic [CW-1:0] X3 = CW'(NCYC - 1);

    typedef enum logic {WORD1, WORD2} phase_t;

    phase_t               phase;
    logic [3:0]           opr_q;
    logic [3:0]           opa_q;
    logic [TEST_SYNC-1:0] sync_q;

    logic first_word;
    logic at_x3;
    logic alu_class;
    logic two_word;
    logic res_zero;
    logic jcn_cond;
    logic dec_acc;
    logic dec_reg;

    assign secondWord = (phase == WORD2);
    assign first_word = (phase == WORD1);
    assign at_x3      = (cycle == X3);
    assign res_zero   = (aluResult == '0);
    assign alu_class  = opr_q inside {4'h6, 4'h8, 4'h9, 4'hA, 4'hD, 4'hF};
    assign two_word   = (opr_q inside {4'h1, 4'h4, 4'h5, 4'h7}) || (opr_q == 4'h2 && !opa_q[0]);
    assign jcn_cond   = ((~testFlag & opa_q[0]) | (carryFlag & opa_q[1]) | (zeroFlag & opa_q[2])) ^ opa_q[3];
    assign useImm     = (opr_q == 4'hD);
    assign testFlag   = sync_q[TEST_SYNC-1];

    always_comb begin
        dec_acc = 1'b0;
        dec_reg = 1'b0;
        case (opr_q)
            4'h8, 4'h9, 4'hA, 4'hD: dec_acc = 1'b1;
            4'hB:                   begin dec_acc = 1'b1; dec_reg = 1'b1; end
            4'h6, 4'h7:             dec_reg = 1'b1;
            4'hF:                   dec_acc = opa_q inside {4'h0, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8,
                                                            4'h9, 4'hB, 4'hC, 4'hD};
            default: ;
        endcase
    end

    // Strobes depend on step so a stalled X1/X3 slot never writes twice.
    assign tempWe    = step && first_word && (cycle == X1);
    assign accWe     = step && first_word && at_x3 && dec_acc;
    assign regWe     = step && first_word && at_x3 && dec_reg;
    assign aluEnable = first_word && (cycle >= X1) && (cycle <= X3) && alu_class;

    always_comb begin
        aluOp = 5'd0;
        if (opr_q == 4'hF)
            aluOp = {1'b1, opa_q};
        else if (alu_class)
            aluOp = {1'b0, opr_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle       <= '0;
            phase       <= WORD1;
            opr_q       <= 4'h0;
            opa_q       <= 4'h0;
            carryFlag   <= 1'b0;
            zeroFlag    <= 1'b0;
            branchTaken <= 1'b0;
        end else if (step) begin
            cycle <= at_x3 ? '0 : cycle + CW'(1);
            if (first_word && cycle == M1) opr_q <= opr;
            if (first_word && cycle == M2) opa_q <= opa;
            if (at_x3) begin
                branchTaken <= 1'b0;
                if (!first_word) begin
                    phase <= WORD1;
                end else begin
                    phase <= two_word ? WORD2 : WORD1;
                    case (opr_q)
                        4'h8, 4'h9: begin carryFlag <= aluCarry; zeroFlag <= res_zero; end
                        4'hA, 4'hD: zeroFlag <= res_zero;
                        4'h7:       branchTaken <= !res_zero;
                        4'h1:       branchTaken <= jcn_cond;
                        4'hF: begin
                            case (opa_q)
                                4'h0:                   begin carryFlag <= 1'b0; zeroFlag <= 1'b1; end
                                4'h1:                   carryFlag <= 1'b0;
                                4'h2, 4'h5, 4'h6, 4'h8: begin carryFlag <= aluCarry; zeroFlag <= res_zero; end
                                4'h3:                   carryFlag <= ~carryFlag;
                                4'h7, 4'h9:             begin carryFlag <= 1'b0; zeroFlag <= res_zero; end
                                4'hA:                   carryFlag <= 1'b1;
                                4'hB:                   begin carryFlag <= carryFlag | aluCarry; zeroFlag <= res_zero; end
                                4'hC, 4'hD:             zeroFlag <= res_zero;
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // TEST is asynchronous; the chain runs every clock, independent of step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= testIn;
            for (int i = 1; i < TEST_SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

endmodule

// File: tb/tb_cc_sequencer.sv
// Bench for cc_sequencer: an instruction-level model checked every clock, plus directed literal checks.
module tb_cc_sequencer;

    localparam int DATA_W    = 4;
    localparam int NCYC      = 8;
    localparam int TEST_SYNC = 2;
    localparam int SLOT_X1   = 5;
    localparam int SLOT_X3   = NCYC - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              step;
    logic [3:0]        opr, opa;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              test_in;

    logic [2:0] cycle;
    logic       second_word, alu_enable, acc_we, reg_we, temp_we;
    logic [4:0] alu_op;
    logic       carry_flag, zero_flag, test_flag, branch_taken, use_imm;

    logic [3:0] cycle10;
    logic       sw10, ae10, acc10, reg10, temp10, carry10, zero10, test10, br10, imm10;
    logic [4:0] op10;

    int n_vec  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int n_reg  = 0;
    int n_temp = 0;

    always #5 clk = ~clk;

    cc_sequencer #(.DATA_W(DATA_W), .NCYC(NCYC), .TEST_SYNC(TEST_SYNC)) u_dut (
        .clk(clk), .rst(rst), .step(step), .opr(opr), .opa(opa),
        .aluResult(alu_result), .aluCarry(alu_carry), .testIn(test_in),
        .cycle(cycle), .secondWord(second_word), .aluEnable(alu_enable), .aluOp(alu_op),
        .accWe(acc_we), .regWe(reg_we), .tempWe(temp_we),
        .carryFlag(carry_flag), .zeroFlag(zero_flag), .testFlag(test_flag),
        .branchTaken(branch_taken), .useImm(use_imm)
    );

    // Ten-slot variant executing STC forever.
    cc_sequencer #(.DATA_W(DATA_W), .NCYC(10), .TEST_SYNC(TEST_SYNC)) u_dut10 (
        .clk(clk), .rst(rst), .step(1'b1), .opr(4'hF), .opa(4'hA),
        .aluResult(4'h0), .aluCarry(1'b0), .testIn(1'b0),
        .cycle(cycle10), .secondWord(sw10), .aluEnable(ae10), .aluOp(op10),
        .accWe(acc10), .regWe(reg10), .tempWe(temp10),
        .carryFlag(carry10), .zeroFlag(zero10), .testFlag(test10),
        .branchTaken(br10), .useImm(imm10)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    int         m_slot;
    bit         m_second, m_carry, m_zero, m_branch, m_test;
    logic [3:0] m_opr, m_opa;
    bit         m_tq[$];

    function automatic bit is_two_word(input logic [3:0] o, input logic [3:0] a);
        return (o == 4'h1) || (o == 4'h4) || (o == 4'h5) || (o == 4'h7) || (o == 4'h2 && a[0] == 1'b0);
    endfunction

    function automatic bit writes_acc(input logic [3:0] o, input logic [3:0] a);
        if (o == 4'hF)
            return a inside {4'h0, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC, 4'hD};
        return o inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hD};
    endfunction

    function automatic bit writes_reg(input logic [3:0] o);
        return o inside {4'h6, 4'h7, 4'hB};
    endfunction

    function automatic bit uses_alu(input logic [3:0] o);
        return o inside {4'h6, 4'h8, 4'h9, 4'hA, 4'hD, 4'hF};
    endfunction

    // Execute the semantic effect of a completed first word.
    task automatic retire(input logic [3:0] o, input logic [3:0] a);
        bit rz;
        bit cond;
        rz   = (alu_result == 0);
        cond = ((!m_test && a[0]) || (m_carry && a[1]) || (m_zero && a[2])) != a[3];
        case (o)
            4'h8, 4'h9: begin m_carry = alu_carry; m_zero = rz; end
            4'hA, 4'hD: m_zero = rz;
            4'h7:       m_branch = !rz;
            4'h1:       m_branch = cond;
            4'hF: begin
                if (a == 4'h0) begin m_carry = 0; m_zero = 1; end
                else if (a == 4'h1) m_carry = 0;
                else if (a == 4'h3) m_carry = !m_carry;
                else if (a == 4'hA) m_carry = 1;
                else if (a == 4'hB) begin m_carry = m_carry | alu_carry; m_zero = rz; end
                else if (a inside {4'h2, 4'h5, 4'h6, 4'h8}) begin m_carry = alu_carry; m_zero = rz; end
                else if (a inside {4'h7, 4'h9}) begin m_carry = 0; m_zero = rz; end
                else if (a inside {4'hC, 4'hD}) m_zero = rz;
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_slot = 0; m_second = 0; m_opr = 0; m_opa = 0;
            m_carry = 0; m_zero = 0; m_branch = 0; m_test = 0;
            m_tq.delete();
            for (int i = 0; i < TEST_SYNC - 1; i++) m_tq.push_back(1'b0);
        end else begin
            if (step) begin
                if (m_slot == SLOT_X3) begin
                    if (m_second) begin
                        m_second = 0;
                        m_branch = 0;
                    end else begin
                        m_branch = 0;
                        retire(m_opr, m_opa);
                        m_second = is_two_word(m_opr, m_opa);
                    end
                end else begin
                    if (!m_second && m_slot == 3) m_opr = opr;
                    if (!m_second && m_slot == 4) m_opa = opa;
                end
                m_slot = (m_slot + 1) % NCYC;
            end
            m_tq.push_back(test_in);
            m_test = m_tq.pop_front();
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        bit         first, e_temp, e_acc, e_reg, e_alu;
        logic [4:0] e_op;
        first  = !m_second;
        e_temp = step && first && m_slot == SLOT_X1;
        e_acc  = step && first && m_slot == SLOT_X3 && writes_acc(m_opr, m_opa);
        e_reg  = step && first && m_slot == SLOT_X3 && writes_reg(m_opr);
        e_alu  = first && m_slot >= SLOT_X1 && m_slot <= SLOT_X3 && uses_alu(m_opr);
        if (m_opr == 4'hF)      e_op = {1'b1, m_opa};
        else if (uses_alu(m_opr)) e_op = {1'b0, m_opr};
        else                      e_op = 5'd0;
        chk("cycle",      32'(cycle),        32'(m_slot));
        chk("secondWord", 32'(second_word),  32'(m_second));
        chk("tempWe",     32'(temp_we),      32'(e_temp));
        chk("accWe",      32'(acc_we),       32'(e_acc));
        chk("regWe",      32'(reg_we),       32'(e_reg));
        chk("aluEnable",  32'(alu_enable),   32'(e_alu));
        chk("aluOp",      32'(alu_op),       32'(e_op));
        chk("useImm",     32'(use_imm),      32'(m_opr == 4'hD));
        chk("carry",      32'(carry_flag),   32'(m_carry));
        chk("zero",       32'(zero_flag),    32'(m_zero));
        chk("test",       32'(test_flag),    32'(m_test));
        chk("branch",     32'(branch_taken), 32'(m_branch));
        n_acc  += int'(acc_we);
        n_reg  += int'(reg_we);
        n_temp += int'(temp_we);
    end

    // ---------------- driver tasks ----------------
    task automatic clr_counts();
        n_acc = 0; n_reg = 0; n_temp = 0;
    endtask

    task automatic run(input logic [3:0] o, input logic [3:0] a, input logic [DATA_W-1:0] r,
                       input logic c, input int n);
        opr = o; opa = a; alu_result = r; alu_carry = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mc(input logic [3:0] o, input logic [3:0] a, input logic [DATA_W-1:0] r, input logic c);
        run(o, a, r, c, NCYC);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; step = 1'b1; opr = 0; opa = 0; alu_result = 0; alu_carry = 0; test_in = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cycle", 32'(cycle), 0);
        chk("rst_carry", 32'(carry_flag), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Reset in the middle of an ADD.
        run(4'h8, 4'h0, 4'h5, 1'b0, 6);
        chk("pre_abort_slot", 32'(cycle), 6);
        rst = 1'b1;
        #1;
        chk("abort_cycle", 32'(cycle), 0);
        chk("abort_acc", 32'(acc_we), 0);
        chk("abort_aluop", 32'(alu_op), 0);
        @(posedge clk); #1 rst = 1'b0;
        clr_counts();
        mc(4'h0, 4'h0, 4'h0, 1'b0);
        chk("nop_acc_count", 32'(n_acc), 0);
        chk("nop_temp_count", 32'(n_temp), 1);

        // ADD with zero result and carry out.
        clr_counts();
        mc(4'h8, 4'h0, 4'h0, 1'b1);
        chk("add_acc_count", 32'(n_acc), 1);
        chk("add_carry", 32'(carry_flag), 1);
        chk("add_zero", 32'(zero_flag), 1);

        // JCN on carry, taken; then inverted, not taken.
        mc(4'h1, 4'h2, 4'h0, 1'b0);
        chk("jcn_c_sw", 32'(second_word), 1);
        chk("jcn_c_br", 32'(branch_taken), 1);
        clr_counts();
        mc(4'h3, 4'h5, 4'h0, 1'b0);
        chk("jcn_w2_temp", 32'(n_temp), 0);
        chk("jcn_w2_br", 32'(branch_taken), 0);
        chk("jcn_w2_sw", 32'(second_word), 0);
        mc(4'h1, 4'hA, 4'h0, 1'b0);
        chk("jcn_nc_br", 32'(branch_taken), 0);
        mc(4'h0, 4'h0, 4'h0, 1'b0);

        // JCN on TEST low, then TEST rises through the synchroniser.
        mc(4'h1, 4'h1, 4'h0, 1'b0);
        chk("jcn_t0_br", 32'(branch_taken), 1);
        mc(4'h0, 4'h0, 4'h0, 1'b0);
        test_in = 1'b1;
        run(4'h0, 4'h0, 4'h0, 1'b0, 1);
        chk("test_1clk", 32'(test_flag), 0);
        run(4'h0, 4'h0, 4'h0, 1'b0, 1);
        chk("test_2clk", 32'(test_flag), 1);
        run(4'h0, 4'h0, 4'h0, 1'b0, NCYC - 2);
        mc(4'h1, 4'h1, 4'h0, 1'b0);
        chk("jcn_t1_br", 32'(branch_taken), 0);
        mc(4'h0, 4'h0, 4'h0, 1'b0);

        // STC stalled at X3.
        mc(4'hF, 4'h1, 4'h0, 1'b0);
        clr_counts();
        run(4'hF, 4'hA, 4'h0, 1'b0, NCYC - 1);
        step = 1'b0;
        run(4'hF, 4'hA, 4'h0, 1'b0, 3);
        chk("stall_cycle", 32'(cycle), SLOT_X3);
        chk("stall_carry", 32'(carry_flag), 0);
        step = 1'b1;
        run(4'hF, 4'hA, 4'h0, 1'b0, 1);
        chk("stc_carry", 32'(carry_flag), 1);
        chk("stc_cycle", 32'(cycle), 0);
        chk("stc_temp_count", 32'(n_temp), 1);

        // ADD stalled at X3: exactly one accumulator write.
        clr_counts();
        run(4'h8, 4'h0, 4'h3, 1'b0, NCYC - 1);
        step = 1'b0;
        run(4'h8, 4'h0, 4'h3, 1'b0, 3);
        step = 1'b1;
        run(4'h8, 4'h0, 4'h3, 1'b0, 1);
        chk("stall_add_acc", 32'(n_acc), 1);
        chk("stall_add_carry", 32'(carry_flag), 0);
        chk("stall_add_zero", 32'(zero_flag), 0);

        // CMC twice from carry clear.
        mc(4'hF, 4'h1, 4'h0, 1'b0);
        mc(4'hF, 4'h3, 4'h0, 1'b0);
        chk("cmc1", 32'(carry_flag), 1);
        mc(4'hF, 4'h3, 4'h0, 1'b0);
        chk("cmc2", 32'(carry_flag), 0);

        // FIM is two words, SRC is one.
        mc(4'h2, 4'h4, 4'h0, 1'b0);
        chk("fim_sw", 32'(second_word), 1);
        mc(4'h0, 4'h0, 4'h0, 1'b0);
        chk("fim_done", 32'(second_word), 0);
        mc(4'h2, 4'h5, 4'h0, 1'b0);
        chk("src_sw", 32'(second_word), 0);

        // ISZ, XCH, LDM, DAA.
        clr_counts();
        mc(4'h7, 4'h0, 4'h3, 1'b0);
        chk("isz_reg", 32'(n_reg), 1);
        chk("isz_br", 32'(branch_taken), 1);
        mc(4'h0, 4'h0, 4'h0, 1'b0);
        clr_counts();
        mc(4'hB, 4'h0, 4'h9, 1'b1);
        chk("xch_acc", 32'(n_acc), 1);
        chk("xch_reg", 32'(n_reg), 1);
        mc(4'hD, 4'h7, 4'h0, 1'b1);
        chk("ldm_zero", 32'(zero_flag), 1);
        chk("ldm_carry", 32'(carry_flag), 0);
        chk("ldm_imm", 32'(use_imm), 1);
        mc(4'hF, 4'hB, 4'h4, 1'b1);
        chk("daa_carry", 32'(carry_flag), 1);
        chk("daa_zero", 32'(zero_flag), 0);
        chk("daa_op", 32'(alu_op), 32'h1B);

        // Ten-slot machine cycle: X3 at slot 9.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("n10_slot9", 32'(cycle10), 9);
        chk("n10_carry_pre", 32'(carry10), 0);
        @(posedge clk); #1;
        chk("n10_wrap", 32'(cycle10), 0);
        chk("n10_carry_post", 32'(carry10), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cc_sequencer.md
# cc_sequencer

Parametrised instruction sequencer and condition-code unit for the TB4004 core: walks the machine-cycle counter, latches OPR/OPA, tracks two-word instructions, generates ALU/register write strobes and owns the carry, zero and test flags. It adds a stall input, configurable data width and cycle count, a synchronised TEST pin, and a registered branch decision for JCN/ISZ. The datapath and program counter consume its outputs.

## Interface
- DATA_W, 4: ALU result width; zero flag is computed over all DATA_W bits.
- NCYC, 8: clocks per machine cycle, ≥8. Fixed slots: M1=3, M2=4, X1=5, X3=NCYC-1.
- TEST_SYNC, 2: synchroniser depth for testIn, ≥1.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- step  in  1  advance enable; low freezes the counter, all state and all write strobes.
- opr  in  4  ROM upper nibble, sampled at M1.
- opa  in  4  ROM lower nibble, sampled at M2.
- aluResult  in  DATA_W  ALU result, valid X1..X3.
- aluCarry  in  1  ALU carry/borrow out.
- testIn  in  1  asynchronous TEST pin.
- cycle  out  clog2(NCYC)  current slot.
- secondWord  out  1  current machine cycle fetches the second word of a two-word instruction.
- aluEnable  out  1  ALU active.
- aluOp  out  5  {0,oprQ} for opcodes 6,8,9,A,D; {1,opaQ} for opcode F; 0 otherwise.
- accWe, regWe, tempWe  out  1  single-clock write strobes.
- carryFlag, zeroFlag, testFlag  out  1  flag registers.
- branchTaken  out  1  registered jump decision.
- useImm  out  1  oprQ==D (LDM).

## Operation
- cycle increments when step=1, wrapping NCYC-1→0. All updates listed below require step=1 on that clock.
- When secondWord=0: oprQ←opr at M1, opaQ←opa at M2. When secondWord=1, oprQ/opaQ hold and no decode strobes fire.
- At X3: secondWord←1 if secondWord=0 and oprQ∈{1 JCN, 4 JUN, 5 JMS, 7 ISZ} or (oprQ=2 and opaQ[0]=0, FIM); otherwise secondWord←0.
- tempWe: X1, first word, every opcode.
- aluEnable: cycle∈[X1,X3], first word, oprQ∈{6,8,9,A,D,F}.
- At X3, first word:
  - 8 ADD, 9 SUB: accWe; carry←aluCarry; zero←(aluResult==0).
  - A LD, D LDM: accWe; zero updated; carry held.
  - B XCH: accWe and regWe.
  - 6 INC: regWe; flags held.
  - 7 ISZ: regWe; branchTaken←(aluResult!=0).
  - 1 JCN: branchTaken←((~testFlag&opaQ[0])|(carryFlag&opaQ[1])|(zeroFlag&opaQ[2]))^opaQ[3].
  - F group by opaQ: 0 CLB accWe, carry←0, zero←1; 1 CLC carry←0; 2 IAC, 5 RAL, 6 RAR, 8 DAC accWe, carry←aluCarry, zero updated; 3 CMC carry←~carry; 7 TCC, 9 TCS accWe, carry←0, zero updated; A STC carry←1; B DAA accWe, carry←carry|aluCarry, zero updated; C KBP, D DCL accWe, zero updated.
  - All other opcodes/opa values: no strobes, flags held.
- branchTaken holds through the second word and clears at its X3.
- testFlag: TEST_SYNC-flop chain of testIn, clocked every clk regardless of step.

## Timing
- Reset: cycle=0, secondWord=0, oprQ=opaQ=0, carry=zero=test=0, sync chain 0, branchTaken=0; hence every output 0.
- Reset mid-instruction aborts it; after release sequencing restarts at slot 0, first word.
- Strobes are combinational from registered state and step, one clock wide; consumers capture on the same edge.
- Flags and branchTaken change on the X3 edge; new values visible from slot 0 of the next machine cycle.
- JCN sees flags as they stood before its own X3; a flag write in the preceding instruction is visible.
- step low at X3 delays all X3 effects until the clock step is high; strobes never repeat.
- testIn reaches testFlag after TEST_SYNC clocks.

## Test plan
- Reset mid-ADD at slot 6 -> all outputs 0; after release cycle counts 0..7 with no accWe.
- ADD, DATA_W=4, aluResult=0, aluCarry=1 -> single accWe at slot 7; carry=1, zero=1 from next slot 0.
- JCN opa=4'b0010 with carry=1 -> secondWord=1 next machine cycle, branchTaken=1 until that X3; opa=4'b1010 -> branchTaken=0.
- testIn 0→1, TEST_SYNC=2, JCN opa=4'b0001 issued immediately -> taken for a 0 test; 2 clocks later testFlag=1 and JCN not taken.
- step held low for 3 clocks at X3 of STC -> cycle frozen, carry unchanged; carry=1 one clock after step returns; no duplicate strobes.
- FIM (opr=2, opa[0]=0) -> two machine cycles, SRC (opa[0]=1) -> one; CMC twice from carry=0 -> 1 then 0; NCYC=10 -> X3 at slot 9.
